// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small synchronous FIFO.
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state; without it
// parity_mode is accepted but ignored and frames never carry a parity bit).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic [1:0]                    parity_mode,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, pop, fifo_empty;
    logic [DATA_BITS-1:0] head;

    // Transmitter state
    logic [2:0]           state_q, state_d;
    logic [15:0]          clk_cnt_q, clk_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_out_q, tx_out_d;
    logic                 bit_done, load;
`ifdef UART_TX_PARITY_EN
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
`else
    logic                 unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    assign s_ready    = (count_q != CW'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign bit_done   = (clk_cnt_q == BIT_LAST);

    assign tx_out     = tx_out_q;
    assign tx_busy    = (state_q != IDLE);
    assign fifo_count = count_q;

    // FIFO pointer/occupancy next-state; pointers wrap naturally (power-of-2 depth)
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Frame sequencer: tx_out_d is the value the line takes after the next edge
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_out_d  = tx_out_q;
        load      = 1'b0;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        if (state_q != IDLE) clk_cnt_d = bit_done ? '0 : clk_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_out_d  = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d  = PARITY;
                            tx_out_d = par_bit_q;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
`else
                        state_d  = STOP;
                        tx_out_d = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_out_d  = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_out_d  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        // chain straight into the next start bit when data waits
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = 1'b1;
            end
        endcase

        if (load) begin
            pop       = 1'b1;
            state_d   = START;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            shreg_d   = head;
            tx_out_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            // parity mode is captured with the word so mid-frame changes are inert
            par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d = (^head) ^ parity_mode[1];
`endif
        end
    end

    // FIFO data array; contents need no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    // State registers; reset aborts any frame and empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_out_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_out_q  <= tx_out_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Reference model expands every accepted word into
// the per-cycle line waveform implied by the frame rules and checks the DUT
// against it every cycle. A second instance covers 5 data bits / 2 stop bits.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int LIM   = 5000;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0, s_valid2 = 1'b0;
    logic [7:0] s_data = '0;
    logic [4:0] s_data2 = '0;
    logic [1:0] parity_mode = 2'b00, parity_mode2 = 2'b00;
    logic       s_ready, tx_out, tx_busy, s_ready2, tx_out2, tx_busy2;
    logic [2:0] fifo_count, fifo_count2;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .parity_mode(parity_mode), .tx_out(tx_out), .tx_busy(tx_busy), .fifo_count(fifo_count));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .parity_mode(parity_mode2), .tx_out(tx_out2), .tx_busy(tx_busy2), .fifo_count(fifo_count2));

    always #5 clk = ~clk;

    typedef struct packed { bit tx; bit busy; bit pop; } elem_t;
    elem_t q0[$], q1[$];
    elem_t e0, e1;
    int    cnt0, cnt1;
    bit    acc0, acc1;
    int    tests = 0, fails = 0;

    // Append one frame (per-cycle expected line values) to model queue `which`.
    task automatic append_frame(input int which, input logic [7:0] w, input int db,
                                input int sb, input logic [1:0] pm);
        bit    bits[$];
        bit    p;
        elem_t el;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            bits.push_back(w[i]);
            p ^= w[i];
        end
        if (PAR_EN && (pm == 2'b01 || pm == 2'b10)) bits.push_back(pm == 2'b10 ? ~p : p);
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        // an idle transmitter needs one cycle to notice the new word
        el = '{tx: 1'b1, busy: 1'b0, pop: 1'b0};
        if (which == 0 && q0.size() == 0) q0.push_back(el);
        if (which == 1 && q1.size() == 0) q1.push_back(el);
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < CPB; c++) begin
                el = '{tx: bits[b], busy: 1'b1, pop: (b == 0 && c == 0)};
                if (which == 0) q0.push_back(el); else q1.push_back(el);
            end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
    endtask

    // Drive one clock of stimulus, advance the model, land on the next negedge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit v2, input logic [7:0] d2);
        s_valid  = v;
        s_data   = d;
        s_valid2 = v2;
        s_data2  = d2[4:0];
        acc0 = v && (cnt0 != DEPTH);
        if (acc0) begin append_frame(0, d, 8, 1, parity_mode); cnt0++; end
        acc1 = v2 && (cnt1 != DEPTH);
        if (acc1) begin append_frame(1, d2, 5, 2, parity_mode2); cnt1++; end
        @(negedge clk);
        e0 = (q0.size() != 0) ? q0.pop_front() : elem_t'{tx: 1'b1, busy: 1'b0, pop: 1'b0};
        e1 = (q1.size() != 0) ? q1.pop_front() : elem_t'{tx: 1'b1, busy: 1'b0, pop: 1'b0};
        if (e0.pop) cnt0--;
        if (e1.pop) cnt1--;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0 || s_ready !== 1'b1 ||
            tx_out2 !== 1'b1 || tx_busy2 !== 1'b0 || fifo_count2 !== 3'd0 || s_ready2 !== 1'b1) begin
            fails++;
            $display("FAIL reset tx=%b busy=%b cnt=%0d rdy=%b / tx2=%b busy2=%b cnt2=%0d rdy2=%b, want 1 0 0 1",
                     tx_out, tx_busy, fifo_count, s_ready, tx_out2, tx_busy2, fifo_count2, s_ready2);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_frame_a5();
        int busy_n;
        busy_n = 0;
        parity_mode = 2'b00;
        for (int i = 0; i < LIM; i++) begin
            if (i > 0 && q0.size() == 0 && cnt0 == 0) break;
            cycle(i == 0, 8'hA5, 1'b0, 8'h00);
            busy_n += int'(tx_busy);
            tests++;
            if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0) || s_ready !== (cnt0 != DEPTH)) begin
                fails++;
                $display("FAIL a5_frame cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b", i,
                         tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0, s_ready);
            end
        end
        tests++;
        if (busy_n !== 160) begin
            fails++;
            $display("FAIL a5_busy_cycles got %0d want 160", busy_n);
        end
    endtask

    task automatic test_parity();
        logic [7:0] wv [4];
        logic [1:0] mv [4];
        int         busy_n;
        wv[0] = 8'h3C; mv[0] = 2'b01;
        wv[1] = 8'h3C; mv[1] = 2'b10;
        wv[2] = 8'h7E; mv[2] = 2'b01;
        wv[3] = 8'hA5; mv[3] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            parity_mode = mv[k];
            busy_n = 0;
            for (int i = 0; i < LIM; i++) begin
                if (i > 0 && q0.size() == 0 && cnt0 == 0) break;
                cycle(i == 0, wv[k], 1'b0, 8'h00);
                busy_n += int'(tx_busy);
                tests++;
                if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0) || s_ready !== (cnt0 != DEPTH)) begin
                    fails++;
                    $display("FAIL parity k=%0d cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d", k, i,
                             tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0);
                end
            end
            tests++;
            if (busy_n !== (PAR_EN ? 176 : 160)) begin
                fails++;
                $display("FAIL parity_len k=%0d got %0d want %0d", k, busy_n, PAR_EN ? 176 : 160);
            end
        end
        parity_mode = 2'b00;
    endtask

    task automatic test_back_to_back();
        int idx, maxc;
        idx = 0;
        maxc = 0;
        parity_mode = 2'b00;
        for (int i = 0; i < LIM; i++) begin
            if (idx == 6 && q0.size() == 0 && cnt0 == 0) break;
            cycle(idx < 6, 8'(idx + 1), 1'b0, 8'h00);
            if (acc0) idx++;
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
            tests++;
            if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0) || s_ready !== (cnt0 != DEPTH)) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b", i,
                         tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0, s_ready);
            end
        end
        tests++;
        if (idx !== 6 || maxc !== DEPTH) begin
            fails++;
            $display("FAIL back_to_back_fill accepted=%0d maxcount=%0d want 6 and %0d", idx, maxc, DEPTH);
        end
    endtask

    task automatic test_parity_change();
        parity_mode = 2'b01;
        for (int i = 0; i < LIM; i++) begin
            if (i > 0 && q0.size() == 0 && cnt0 == 0) break;
            if (i == 20) parity_mode = 2'b10;
            cycle(i == 0, 8'h3C, 1'b0, 8'h00);
            tests++;
            if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0)) begin
                fails++;
                $display("FAIL parity_change cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d", i,
                         tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0);
            end
        end
        parity_mode = 2'b00;
    endtask

    task automatic test_reset_midframe();
        parity_mode = 2'b00;
        for (int i = 0; i < 70; i++) begin
            cycle(i < 3, 8'hC3 + 8'(i), 1'b0, 8'h00);
            tests++;
            if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0)) begin
                fails++;
                $display("FAIL midframe_pre cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d", i,
                         tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0);
            end
        end
        #3 rst = 1'b1;
        #1;
        model_reset();
        tests++;
        if (tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL midframe_async tx=%b busy=%b cnt=%0d rdy=%b want 1 0 0 1",
                     tx_out, tx_busy, fifo_count, s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LIM; i++) begin
            if (i > 0 && q0.size() == 0 && cnt0 == 0) break;
            cycle(i == 0, 8'h55, 1'b0, 8'h00);
            tests++;
            if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0) || s_ready !== (cnt0 != DEPTH)) begin
                fails++;
                $display("FAIL midframe_post cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d", i,
                         tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0);
            end
        end
    endtask

    task automatic test_short_frame();
        int busy_n;
        busy_n = 0;
        for (int i = 0; i < LIM; i++) begin
            if (i > 1 && q1.size() == 0 && cnt1 == 0) break;
            cycle(1'b0, 8'h00, i < 2, (i == 0) ? 8'h1F : 8'h00);
            busy_n += int'(tx_busy2);
            tests++;
            if (tx_out2 !== e1.tx || tx_busy2 !== e1.busy || fifo_count2 !== 3'(cnt1) || s_ready2 !== (cnt1 != DEPTH)) begin
                fails++;
                $display("FAIL short_frame cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d", i,
                         tx_out2, e1.tx, tx_busy2, e1.busy, fifo_count2, cnt1);
            end
        end
        tests++;
        if (busy_n !== 2 * (CPB + 5 * CPB + 2 * CPB)) begin
            fails++;
            $display("FAIL short_frame_len got %0d want %0d", busy_n, 2 * 8 * CPB);
        end
    endtask

    task automatic test_random();
        for (int batch = 0; batch < 4; batch++) begin
            parity_mode = 2'($urandom_range(0, 3));
            for (int i = 0; i < 300; i++) begin
                cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 8'h00);
                tests++;
                if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0) || s_ready !== (cnt0 != DEPTH)) begin
                    fails++;
                    $display("FAIL random b=%0d cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d rdy=%b", batch, i,
                             tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0, s_ready);
                end
            end
            for (int i = 0; i < LIM; i++) begin
                if (q0.size() == 0 && cnt0 == 0) break;
                cycle(1'b0, 8'h00, 1'b0, 8'h00);
                tests++;
                if (tx_out !== e0.tx || tx_busy !== e0.busy || fifo_count !== 3'(cnt0) || s_ready !== (cnt0 != DEPTH)) begin
                    fails++;
                    $display("FAIL random_drain b=%0d cyc=%0d tx=%b/%b busy=%b/%b cnt=%0d/%0d", batch, i,
                             tx_out, e0.tx, tx_busy, e0.busy, fifo_count, cnt0);
                end
            end
            tests++;
            if (q0.size() != 0) begin
                fails++;
                $display("FAIL random_timeout b=%0d pending=%0d want 0", batch, q0.size());
            end
        end
        parity_mode = 2'b00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_frame_a5();
        test_parity();
        test_back_to_back();
        test_parity_change();
        test_reset_midframe();
        test_short_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200); legal range 4 to 65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5 to 8.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 and 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port s_valid, input, 1 bit: write request.
REQ-008 SHALL have port s_ready, output, 1 bit: FIFO can accept.
REQ-009 SHALL have port s_data, input, DATA_BITS bits: word to send.
REQ-010 SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 none.
REQ-011 SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port tx_busy, output, 1 bit: frame in progress.
REQ-013 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: occupied entries.

Function
REQ-014 SHALL write s_data into the FIFO on a rising edge where s_valid and s_ready are both high; s_data is ignored otherwise.
REQ-015 SHALL drive s_ready = (fifo_count != FIFO_DEPTH), combinationally from registered count; when full, a push is refused even if a pop occurs on the same edge.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; tx_busy = (state != IDLE).
REQ-017 In IDLE with FIFO non-empty, SHALL pop the head word, latch it and parity_mode, and enter START on the next edge: tx_out falls 1 cycle after the push edge into an empty, idle block.
REQ-018 SHALL hold every bit on tx_out for exactly CLKS_PER_BIT cycles, using a registered tx_out with no glitches.
REQ-019 Frame order SHALL be: start (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-020 Parity bit SHALL be XOR of data bits for even and its inverse for odd; PARITY is skipped for modes 00/11.
REQ-021 Changes to parity_mode mid-frame SHALL NOT affect the frame in progress.
REQ-022 At the end of the last stop bit, SHALL go directly to START if the FIFO is non-empty (no idle cycles between frames); otherwise go to IDLE with tx_out=1.
REQ-023 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 While rst is high, SHALL force, asynchronously: tx_out=1, tx_busy=0, fifo_count=0, s_ready=1, state IDLE, FIFO pointers 0, bit/clock counters 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately and discard all queued words; the first push after reset release SHALL transmit normally.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, SHALL implement parity per REQ-020.
REQ-027 With UART_TX_PARITY_EN undefined, SHALL ignore parity_mode, omit the PARITY state logic and always send frames without parity; the port SHALL remain present.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4 unless stated)
REQ-028 Push 0xA5, parity 00 -> tx_out per 16 cycles: 0,1,0,1,0,0,1,0,1,1; total 160 cycles; tx_busy high throughout, then low.
REQ-029 Macro defined: push 0x3C even -> parity bit 0; push 0x3C odd -> parity bit 1; push 0x7E even -> parity bit 0; frame 176 cycles each.
REQ-030 Hold s_valid with 6 words 0x01 to 0x06 -> s_ready low while fifo_count=4; all 6 sent in order with no gap between stop and next start bit.
REQ-031 Assert rst during data bit 3 with 2 words queued -> tx_out=1, tx_busy=0, fifo_count=0 at once; after release, push 0x55 -> correct single frame only.
REQ-032 STOP_BITS=2, DATA_BITS=5: push 0x1F then 0x00 -> high for 32 cycles between frames; 5 data bits per frame; upper bits ignored.
REQ-033 Macro undefined, parity_mode=01: push 0xA5 -> frame identical to REQ-028.
